uart_alu_engine: RTL

//  Byte-stream packet ALU: parses opcode/length packets from the UART RX stream and folds N operands of

---
 rtl/uart_alu_engine.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_alu_engine.sv
// ============================================================================
// uart_alu_engine : packet ALU between a UART RX stream and its TX stream
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_alu_engine #(
  parameter int unsigned OPERAND_BYTES = 4,
  parameter logic [7:0]  ERR_BYTE      = 8'hEE
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] rx_tdata_i,
  input  logic       rx_tvalid_i,
  output logic       rx_tready_o,
  output logic [7:0] tx_tdata_o,
  output logic       tx_tvalid_o,
  input  logic       tx_tready_i,
  output logic       busy_o,
  output logic       err_o
);

  localparam int unsigned    c_w          = 8 * OPERAND_BYTES;
  localparam int unsigned    c_bw         = (OPERAND_BYTES > 1) ? $clog2(OPERAND_BYTES) : 1;
  localparam int unsigned    c_mw         = $clog2(c_w) + 1;
  localparam logic [c_bw-1:0] c_bcnt_last = c_bw'(OPERAND_BYTES - 1);
  localparam logic [c_mw-1:0] c_mul_last  = c_mw'(c_w - 1);
  localparam logic [c_mw-1:0] c_send_all  = c_mw'(OPERAND_BYTES);
  localparam logic [15:0]    c_min_p      = 16'(2 * OPERAND_BYTES);
  localparam logic [15:0]    c_p_mask     = 16'(OPERAND_BYTES - 1);

  localparam logic [7:0] c_op_add  = 8'h01;
  localparam logic [7:0] c_op_mul  = 8'h02;
  localparam logic [7:0] c_op_sub  = 8'h04;
  localparam logic [7:0] c_op_and  = 8'h05;
  localparam logic [7:0] c_op_or   = 8'h06;
  localparam logic [7:0] c_op_xor  = 8'h07;
  localparam logic [7:0] c_op_echo = 8'hEC;

  typedef enum logic [3:0] {
    ST_IDLE, ST_RSVD, ST_LEN_LO, ST_LEN_HI, ST_ECHO, ST_LOAD_A, ST_LOAD_B,
    ST_EXEC, ST_MUL_RUN, ST_SEND, ST_DRAIN, ST_SEND_ERR
  } state_t;

  state_t          state_q;
  logic [7:0]      op_q;
  logic [7:0]      len_lo_q;
  logic [15:0]     p_q;
  logic [c_bw-1:0] bcnt_q;
  logic [c_mw-1:0] mcnt_q;
  logic [c_w-1:0]  acc_q;
  logic [c_w-1:0]  opnd_q;
  logic [c_w-1:0]  prod_q;
  logic [7:0]      tx_tdata_q;
  logic            tx_tvalid_q;
  logic            err_q;

  logic [15:0]     w_len;
  logic [15:0]     w_plen;
  logic            w_len_ok;
  logic            w_op_known;
  logic            w_rx_fire;
  logic            w_tx_fire;
  logic [c_w-1:0]  w_alu;
  logic [c_w-1:0]  w_mul_add;

  assign w_len      = {rx_tdata_i, len_lo_q};
  assign w_plen     = (w_len < 16'd4) ? 16'd0 : (w_len - 16'd4);
  assign w_len_ok   = (w_plen >= c_min_p) && ((w_plen & c_p_mask) == 16'd0);
  assign w_op_known = (rx_tdata_i inside {c_op_add, c_op_mul, c_op_sub, c_op_and,
                                          c_op_or, c_op_xor, c_op_echo});
  assign w_rx_fire  = rx_tvalid_i && rx_tready_o;
  assign w_tx_fire  = tx_tvalid_q && tx_tready_i;
  // Shift-add step: multiplicand in acc_q shifts left, multiplier in opnd_q shifts right.
  assign w_mul_add  = opnd_q[0] ? (prod_q + acc_q) : prod_q;

  always_comb begin
    w_alu = acc_q;
    case (op_q)
      c_op_add: w_alu = acc_q + opnd_q;
      c_op_sub: w_alu = acc_q - opnd_q;
      c_op_and: w_alu = acc_q & opnd_q;
      c_op_or:  w_alu = acc_q | opnd_q;
      c_op_xor: w_alu = acc_q ^ opnd_q;
      default:  w_alu = acc_q;
    endcase
  end

  always_comb begin
    rx_tready_o = 1'b0;
    case (state_q)
      ST_IDLE, ST_RSVD, ST_LEN_LO, ST_LEN_HI, ST_LOAD_A, ST_LOAD_B: rx_tready_o = 1'b1;
      ST_ECHO:  rx_tready_o = (p_q != 16'd0) && (!tx_tvalid_q || tx_tready_i);
      ST_DRAIN: rx_tready_o = (p_q != 16'd0);
      default:  rx_tready_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      len_lo_q    <= '0;
      p_q         <= '0;
      bcnt_q      <= '0;
      mcnt_q      <= '0;
      acc_q       <= '0;
      opnd_q      <= '0;
      prod_q      <= '0;
      tx_tdata_q  <= '0;
      tx_tvalid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (w_rx_fire && w_op_known) begin
          op_q    <= rx_tdata_i;
          state_q <= ST_RSVD;
        end
        ST_RSVD: if (w_rx_fire) state_q <= ST_LEN_LO;
        ST_LEN_LO: if (w_rx_fire) begin
          len_lo_q <= rx_tdata_i;
          state_q  <= ST_LEN_HI;
        end
        ST_LEN_HI: if (w_rx_fire) begin
          p_q    <= w_plen;
          bcnt_q <= '0;
          if (op_q == c_op_echo) begin
            state_q <= (w_plen != 16'd0) ? ST_ECHO : ST_IDLE;
          end else if (w_len_ok) begin
            state_q <= ST_LOAD_A;
          end else begin
            state_q <= ST_DRAIN;
            err_q   <= 1'b1;
          end
        end
        ST_ECHO: begin
          if (w_rx_fire) begin
            tx_tdata_q  <= rx_tdata_i;
            tx_tvalid_q <= 1'b1;
            p_q         <= p_q - 16'd1;
          end else if (w_tx_fire) begin
            tx_tvalid_q <= 1'b0;
          end
          if ((p_q == 16'd0) && (!tx_tvalid_q || w_tx_fire)) state_q <= ST_IDLE;
        end
        ST_LOAD_A: if (w_rx_fire) begin
          acc_q[{bcnt_q, 3'b000} +: 8] <= rx_tdata_i;
          p_q <= p_q - 16'd1;
          if (bcnt_q == c_bcnt_last) begin
            bcnt_q  <= '0;
            state_q <= ST_LOAD_B;
          end else begin
            bcnt_q <= bcnt_q + c_bw'(1);
          end
        end
        ST_LOAD_B: if (w_rx_fire) begin
          opnd_q[{bcnt_q, 3'b000} +: 8] <= rx_tdata_i;
          p_q <= p_q - 16'd1;
          if (bcnt_q == c_bcnt_last) begin
            bcnt_q  <= '0;
            mcnt_q  <= '0;
            prod_q  <= '0;
            state_q <= (op_q == c_op_mul) ? ST_MUL_RUN : ST_EXEC;
          end else begin
            bcnt_q <= bcnt_q + c_bw'(1);
          end
        end
        ST_EXEC: begin
          acc_q   <= w_alu;
          mcnt_q  <= '0;
          state_q <= (p_q != 16'd0) ? ST_LOAD_B : ST_SEND;
        end
        ST_MUL_RUN: begin
          if (mcnt_q == c_mul_last) begin
            acc_q   <= w_mul_add;
            mcnt_q  <= '0;
            state_q <= (p_q != 16'd0) ? ST_LOAD_B : ST_SEND;
          end else begin
            prod_q <= w_mul_add;
            acc_q  <= acc_q << 1;
            opnd_q <= opnd_q >> 1;
            mcnt_q <= mcnt_q + c_mw'(1);
          end
        end
        // mcnt_q counts bytes loaded into the tx register; the last handshake closes the packet.
        ST_SEND: if (w_tx_fire || !tx_tvalid_q) begin
          if (mcnt_q == c_send_all) begin
            tx_tvalid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            tx_tdata_q  <= acc_q[7:0];
            tx_tvalid_q <= 1'b1;
            acc_q       <= acc_q >> 8;
            mcnt_q      <= mcnt_q + c_mw'(1);
          end
        end
        ST_DRAIN: begin
          if (p_q == 16'd0) begin
            state_q <= ST_SEND_ERR;
          end else if (w_rx_fire) begin
            p_q <= p_q - 16'd1;
            if (p_q == 16'd1) state_q <= ST_SEND_ERR;
          end
        end
        ST_SEND_ERR: begin
          if (!tx_tvalid_q) begin
            tx_tdata_q  <= ERR_BYTE;
            tx_tvalid_q <= 1'b1;
          end else if (tx_tready_i) begin
            tx_tvalid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_tdata_o  = tx_tdata_q;
  assign tx_tvalid_o = tx_tvalid_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign err_o       = err_q;

endmodule

`default_nettype wire
